led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Controller that sequences the board's 8-LED bank. Two pushbuttons select the display mode and the step rate. Two slide switches set the direction and pause stepping.
- Owns the step prescaler, the position register and the mode FSM.
- Drives a registered 8-bit LED pattern straight to the LED pins.
- Sits between the raw KEY/SW pins and the LED outputs at top level.

Parameters:
TICK_BITS, 23, prescaler width; speed-0 step period = 2^TICK_BITS clk cycles; must be >= 4
DEB_CYCLES, 1000000, stable cycles needed to accept a key level change (20 ms at 50 MHz); must be >= 2

Ports:
clk  in  1  50 MHz system clock, single clock domain
rst_n  in  1  asynchronous reset, active-low
key_mode_n  in  1  raw pushbutton, active-low, asynchronous; press advances mode
key_speed_n  in  1  raw pushbutton, active-low, asynchronous; press advances speed
sw_dir  in  1  raw slide switch; 1 = up (pos+1), 0 = down (pos-1)
sw_pause  in  1  raw slide switch; 1 = ignore step ticks
led  out  8  LED pattern, registered
mode  out  2  current mode: 0 CYCLE, 1 BOUNCE, 2 FILL, 3 HOLD
speed  out  2  current speed index 0..3

Behaviour:
- Interface: one clock (clk); rst_n is asynchronous, active-low. All state clears immediately on rst_n=0; release is used synchronously.
- Reset values: led=8'h01, mode=CYCLE, speed=0, pos=0, bounce_dir=up, prescaler=0, debouncers idle (key released), all sync flops=1 for keys and 0 for switches.
- Input synchronisation:
  - All four raw inputs pass through 2-flop synchronisers.
  - Switches are not debounced.
- Key debounce:
  - The debounced level changes only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A press event is a 1-cycle pulse on a debounced 1->0 transition. Release generates no event.
- Prescaler:
  - Counter of TICK_BITS bits. tick=1 for one cycle when count == 2^(TICK_BITS-speed)-1; count clears on that cycle.
  - count also clears on any mode or speed press event.
  - Ticks are generated while paused but not consumed.
- Step = tick & ~sw_pause & (mode != HOLD).
- Mode FSM (CYCLE -> BOUNCE -> FILL -> HOLD -> CYCLE on each mode press):
  - CYCLE: pos = pos±1 mod 8 per step, per sw_dir. Wraps 7->0 (up) and 0->7 (down). led = one-hot(pos).
  - BOUNCE: ignores sw_dir. pos moves in bounce_dir. On a step at pos=7 going up: bounce_dir<=down and pos<=6. Symmetric at 0. led = one-hot(pos).
  - FILL: ignores sw_dir. pos increments, wrapping 7->0. led = (2^(pos+1))-1, a thermometer from bit 0.
  - HOLD: pos and led frozen at the value held on entry.
- On a mode press: pos<=0 and bounce_dir<=up. led updates to the new mode's pattern for pos=0 on the next cycle. HOLD entry is the exception: led keeps its last value.
- Speed press: speed <= speed+1 mod 4 (3 wraps to 0). The change takes effect on the next prescaler period.
- Simultaneous events:
  - Mode and speed press in the same cycle: both applied.
  - Mode press coinciding with a step: the mode press wins and the step is discarded.
- Latency:
  - led changes exactly 1 clk after the step cycle.
  - mode and speed outputs change 1 clk after the press pulse.
- Reset mid-sequence returns all outputs to their reset values asynchronously. The first step after release occurs 2^TICK_BITS cycles later.

Optional Feature:
Macro LED_TRAIL_EN.
- Defined:
  - In CYCLE and BOUNCE, the previously lit position is also driven at 25% duty: on when prescaler[1:0]==2'b00.
  - prev_pos register: resets to 0, loads pos on each step. It is cleared equal to pos on a mode press, so no trail shows.
- Undefined: no prev_pos register. led is exactly as described above. No PWM logic.

Decomposition:
- Package led_seq_pkg:
  - mode_t enum (MODE_CYCLE=2'd0, MODE_BOUNCE, MODE_FILL, MODE_HOLD).
  - LED_COUNT=8, POS_W=3, SPEED_W=2.
- Sub-module key_debounce:
  - Contains synchroniser, DEB_CYCLES counter, debounced level and press pulse.
  - Instantiated once per key.
- Everything else stays in led_seq_ctrl.

Test Plan:
All scenarios use TICK_BITS=4 and DEB_CYCLES=8.
- Reset and speed-0 CYCLE up: hold rst_n=0 -> led=8'h01, mode=0, speed=0. Release with sw_dir=1, sw_pause=0 -> led steps 01,02,04,...,80,01 every 16 clks.
- CYCLE down: sw_dir=0 -> led 01->80->40.
- Speed: press key_speed_n three times -> speed=3 and step period=2 clks. A fourth press gives speed=0.
- Debounce and BOUNCE:
  - key_mode_n pulsed low for 5 clks, repeated 3 times -> no mode change.
  - Held low for 20 clks -> mode=1 with exactly one event; led=01.
  - Then led shows 02,...,80,40,...,01,02.
- FILL, HOLD, pause and collision:
  - Second mode press -> led 01,03,07,...,FF,01.
  - Third press -> HOLD; led frozen for 200 clks.
  - sw_pause=1 in CYCLE -> led frozen; sw_pause=0 -> resumes.
  - Mode press on the tick cycle -> pos=0 and no step.
- Async reset mid-BOUNCE at pos=5 going down: rst_n low for a partial cycle -> outputs return to reset values with no clk edge. After release, the first step occurs at clk 16.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types, sizes and pattern helpers for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_CYCLE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    localparam int LED_COUNT = 8;
    localparam int POS_W     = 3;
    localparam int SPEED_W   = 2;

    // Single lit LED at the given position.
    function automatic logic [LED_COUNT-1:0] pos_onehot(input logic [POS_W-1:0] pos);
        pos_onehot = {{(LED_COUNT-1){1'b0}}, 1'b1} << pos;
    endfunction

    // Thermometer from bit 0 up to and including the given position.
    function automatic logic [LED_COUNT-1:0] pos_thermo(input logic [POS_W-1:0] pos);
        logic [LED_COUNT-1:0] t;
        for (int i = 0; i < LED_COUNT; i++) begin
            t[i] = (i <= int'(pos));
        end
        pos_thermo = t;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted release->press transition.
module key_debounce
    import led_seq_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchronise the raw key, then accept a new level only after it has been
    // stable for DEB_CYCLES cycles; any bounce back to the old level restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                    press_r <= ~sync2_r;
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                    press_r <= 1'b0;
                end
            end else begin
                cnt_r   <= '0;
                press_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/led_seq_ctrl.sv
// 8-LED sequencer: mode/speed keys, direction and pause switches, step
// prescaler and pattern FSM. Optional macro LED_TRAIL_EN adds a 25%-duty
// trail on the previously lit LED in CYCLE and BOUNCE modes.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_BITS  = 23,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_mode_n,
    input  logic                 key_speed_n,
    input  logic                 sw_dir,
    input  logic                 sw_pause,
    output logic [LED_COUNT-1:0] led,
    output logic [1:0]           mode,
    output logic [SPEED_W-1:0]   speed
);

    logic                 mode_press_s;
    logic                 speed_press_s;
    logic                 dir_sync1_r, dir_sync2_r;
    logic                 pause_sync1_r, pause_sync2_r;
    logic [TICK_BITS-1:0] presc_r;
    logic [TICK_BITS-1:0] presc_last_s;
    logic                 tick_s;
    logic                 step_s;
    logic [SPEED_W-1:0]   speed_r;
    mode_t                mode_r, mode_nxt_s;
    logic [POS_W-1:0]     pos_r, pos_nxt_s;
    logic                 bdir_up_r, bdir_up_nxt_s;
    logic [LED_COUNT-1:0] led_r, led_nxt_s;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .press (mode_press_s)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_speed (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_speed_n),
        .press (speed_press_s)
    );

    // Two-flop synchronisers for the slide switches (no debounce needed).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_sync1_r   <= 1'b0;
            dir_sync2_r   <= 1'b0;
            pause_sync1_r <= 1'b0;
            pause_sync2_r <= 1'b0;
        end else begin
            dir_sync1_r   <= sw_dir;
            dir_sync2_r   <= dir_sync1_r;
            pause_sync1_r <= sw_pause;
            pause_sync2_r <= pause_sync1_r;
        end
    end

    // Period at speed s is 2^(TICK_BITS-s) cycles, so the terminal count is
    // the all-ones value shifted right by s. Pause does not gate the tick.
    assign presc_last_s = {TICK_BITS{1'b1}} >> speed_r;
    assign tick_s       = (presc_r == presc_last_s);
    assign step_s       = tick_s & ~pause_sync2_r & (mode_r != MODE_HOLD) & ~mode_press_s;

    // Prescaler restarts on its own tick and on any key press so a new
    // speed or mode always begins with a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else if (mode_press_s || speed_press_s || tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + TICK_BITS'(1);
        end
    end

    // Speed index advances on each speed press, wrapping 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_r <= '0;
        end else if (speed_press_s) begin
            speed_r <= speed_r + SPEED_W'(1);
        end else begin
            speed_r <= speed_r;
        end
    end

    // Next mode/position/bounce direction; a mode press overrides a step.
    always_comb begin
        mode_nxt_s    = mode_r;
        pos_nxt_s     = pos_r;
        bdir_up_nxt_s = bdir_up_r;
        if (mode_press_s) begin
            case (mode_r)
                MODE_CYCLE:  mode_nxt_s = MODE_BOUNCE;
                MODE_BOUNCE: mode_nxt_s = MODE_FILL;
                MODE_FILL:   mode_nxt_s = MODE_HOLD;
                default:     mode_nxt_s = MODE_CYCLE;
            endcase
            pos_nxt_s     = '0;
            bdir_up_nxt_s = 1'b1;
        end else if (step_s) begin
            case (mode_r)
                MODE_CYCLE: begin
                    if (dir_sync2_r) begin
                        pos_nxt_s = pos_r + POS_W'(1);
                    end else begin
                        pos_nxt_s = pos_r - POS_W'(1);
                    end
                end
                MODE_BOUNCE: begin
                    if (bdir_up_r) begin
                        if (pos_r == POS_W'(LED_COUNT - 1)) begin
                            bdir_up_nxt_s = 1'b0;
                            pos_nxt_s     = POS_W'(LED_COUNT - 2);
                        end else begin
                            pos_nxt_s = pos_r + POS_W'(1);
                        end
                    end else begin
                        if (pos_r == POS_W'(0)) begin
                            bdir_up_nxt_s = 1'b1;
                            pos_nxt_s     = POS_W'(1);
                        end else begin
                            pos_nxt_s = pos_r - POS_W'(1);
                        end
                    end
                end
                MODE_FILL: pos_nxt_s = pos_r + POS_W'(1);
                default:   pos_nxt_s = pos_r;
            endcase
        end else begin
            pos_nxt_s = pos_r;
        end
    end

`ifdef LED_TRAIL_EN
    logic [POS_W-1:0] prev_pos_r, prev_pos_nxt_s;

    // Trail source: last position before each step; equal to pos after a
    // mode press so the trail starts dark.
    always_comb begin
        if (mode_press_s) begin
            prev_pos_nxt_s = '0;
        end else if (step_s) begin
            prev_pos_nxt_s = pos_r;
        end else begin
            prev_pos_nxt_s = prev_pos_r;
        end
    end

    // Register the trail position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pos_r <= '0;
        end else begin
            prev_pos_r <= prev_pos_nxt_s;
        end
    end
`endif

    // LED pattern for the next state; HOLD keeps whatever is showing.
    always_comb begin
        led_nxt_s = led_r;
        case (mode_nxt_s)
            MODE_CYCLE, MODE_BOUNCE: begin
`ifdef LED_TRAIL_EN
                if (presc_r[1:0] == 2'b00) begin
                    led_nxt_s = pos_onehot(pos_nxt_s) | pos_onehot(prev_pos_nxt_s);
                end else begin
                    led_nxt_s = pos_onehot(pos_nxt_s);
                end
`else
                led_nxt_s = pos_onehot(pos_nxt_s);
`endif
            end
            MODE_FILL: led_nxt_s = pos_thermo(pos_nxt_s);
            default:   led_nxt_s = led_r;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= MODE_CYCLE;
            pos_r     <= '0;
            bdir_up_r <= 1'b1;
            led_r     <= {{(LED_COUNT-1){1'b0}}, 1'b1};
        end else begin
            mode_r    <= mode_nxt_s;
            pos_r     <= pos_nxt_s;
            bdir_up_r <= bdir_up_nxt_s;
            led_r     <= led_nxt_s;
        end
    end

    assign led   = led_r;
    assign mode  = mode_r;
    assign speed = speed_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_BITS=4, DEB_CYCLES=8.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_mode_n;
    logic       key_speed_n;
    logic       sw_dir;
    logic       sw_pause;
    logic [7:0] led;
    logic [1:0] mode;
    logic [1:0] speed;

    int n_cmp = 0;
    int n_bad = 0;

    led_seq_ctrl #(.TICK_BITS(4), .DEB_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_speed_n (key_speed_n),
        .sw_dir      (sw_dir),
        .sw_pause    (sw_pause),
        .led         (led),
        .mode        (mode),
        .speed       (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        logic       dir;
        logic       pause;
        logic [7:0] led;
        logic [1:0] mode;
        logic [1:0] speed;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Cycles until led changes, or -1 if it stays put for 'limit' cycles.
    task automatic wait_change(input int limit, output int n);
        logic [7:0] prev;
        prev = led;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (led !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_mode(input logic [1:0] m, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mode === m) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press_speed();
        key_speed_n = 1'b0;
        repeat (20) @(negedge clk);
        key_speed_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic press_mode(input logic [1:0] m);
        int n;
        key_mode_n = 1'b0;
        wait_mode(m, 30, n);
        check($sformatf("mode%0d_latency", m), n, 32'd11);
        key_mode_n = 1'b1;
    endtask

    task automatic check_run(input string nm, input logic [7:0] exp[], input int period);
        int n;
        for (int i = 0; i < exp.size(); i++) begin
            wait_change(period + 4, n);
            check($sformatf("%s_period%0d", nm, i), n, period);
            check($sformatf("%s_led%0d", nm, i), int'(led), int'(exp[i]));
        end
    endtask

    initial begin
        int n;
        logic [7:0] prev;
        logic [7:0] bounce_exp[];
        logic [7:0] fill_exp[];
        logic [7:0] col_exp[];

        vecs[0]  = '{15, 1'b1, 1'b0, 8'h01, 2'd0, 2'd0};
        vecs[1]  = '{1,  1'b1, 1'b0, 8'h02, 2'd0, 2'd0};
        vecs[2]  = '{16, 1'b1, 1'b0, 8'h04, 2'd0, 2'd0};
        vecs[3]  = '{16, 1'b1, 1'b0, 8'h08, 2'd0, 2'd0};
        vecs[4]  = '{16, 1'b1, 1'b0, 8'h10, 2'd0, 2'd0};
        vecs[5]  = '{16, 1'b1, 1'b0, 8'h20, 2'd0, 2'd0};
        vecs[6]  = '{16, 1'b1, 1'b0, 8'h40, 2'd0, 2'd0};
        vecs[7]  = '{16, 1'b1, 1'b0, 8'h80, 2'd0, 2'd0};
        vecs[8]  = '{16, 1'b1, 1'b0, 8'h01, 2'd0, 2'd0};
        vecs[9]  = '{16, 1'b0, 1'b0, 8'h80, 2'd0, 2'd0};
        vecs[10] = '{16, 1'b0, 1'b0, 8'h40, 2'd0, 2'd0};
        vecs[11] = '{16, 1'b1, 1'b1, 8'h40, 2'd0, 2'd0};
        vecs[12] = '{16, 1'b1, 1'b1, 8'h40, 2'd0, 2'd0};
        vecs[13] = '{16, 1'b1, 1'b0, 8'h80, 2'd0, 2'd0};
        vecs[14] = '{16, 1'b1, 1'b0, 8'h01, 2'd0, 2'd0};

        bounce_exp = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        fill_exp   = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01, 8'h03};
        col_exp    = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
        sw_dir      = 1'b1;
        sw_pause    = 1'b0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", int'(led), 32'h01);
        check("rst_mode", int'(mode), 32'd0);
        check("rst_speed", int'(speed), 32'd0);
        rst_n = 1'b1;

        // CYCLE up/down, wrap both ways, pause and resume.
        for (int i = 0; i < 15; i++) begin
            sw_dir   = vecs[i].dir;
            sw_pause = vecs[i].pause;
            repeat (vecs[i].cycles) @(negedge clk);
            check($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].led));
            check($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].mode));
            check($sformatf("vec%0d_speed", i), int'(speed), int'(vecs[i].speed));
        end

        // Speed presses: 3 presses -> period 2, fourth wraps to speed 0.
        for (int i = 1; i <= 3; i++) begin
            press_speed();
            check($sformatf("speed_after_%0d", i), int'(speed), i);
        end
        wait_change(8, n);
        check("spd3_align", int'(n > 0), 32'd1);
        for (int k = 0; k < 2; k++) begin
            prev = led;
            wait_change(4, n);
            check($sformatf("spd3_period%0d", k), n, 32'd2);
            check($sformatf("spd3_led%0d", k), int'(led), int'({prev[6:0], prev[7]}));
        end
        press_speed();
        check("speed_wrap", int'(speed), 32'd0);
        wait_change(20, n);
        check("spd0_align", int'(n > 0), 32'd1);
        prev = led;
        wait_change(20, n);
        check("spd0_period", n, 32'd16);
        check("spd0_led", int'(led), int'({prev[6:0], prev[7]}));

        // Short glitches on the mode key are rejected.
        for (int i = 0; i < 3; i++) begin
            key_mode_n = 1'b0;
            repeat (5) @(negedge clk);
            key_mode_n = 1'b1;
            repeat (5) @(negedge clk);
        end
        check("glitch_mode", int'(mode), 32'd0);

        // Long press: exactly one event into BOUNCE.
        key_mode_n = 1'b0;
        wait_mode(2'd1, 30, n);
        check("bounce_latency", n, 32'd11);
        check("bounce_entry_led", int'(led), 32'h01);
        repeat (9) @(negedge clk);
        key_mode_n = 1'b1;
        wait_change(20, n);
        check("bounce_first_period", n, 32'd7);
        check("bounce_first_led", int'(led), 32'h02);
        check_run("bounce", bounce_exp, 16);
        check("bounce_one_event", int'(mode), 32'd1);

        // FILL thermometer, then HOLD right after the 03 pattern.
        press_mode(2'd2);
        check("fill_entry_led", int'(led), 32'h01);
        check_run("fill", fill_exp, 16);
        press_mode(2'd3);
        check("hold_entry_led", int'(led), 32'h03);
        wait_change(200, n);
        check("hold_frozen", n, -1);
        check("hold_led", int'(led), 32'h03);
        check("hold_mode", int'(mode), 32'd3);

        // Back to CYCLE; prescaler restarted by the press.
        press_mode(2'd0);
        check("cycle_entry_led", int'(led), 32'h01);
        wait_change(20, n);
        check("cycle_reentry_period", n, 32'd16);
        check("cycle_reentry_led", int'(led), 32'h02);

        // Speed press restarts the prescaler at speed 1 (period 8); the mode
        // press is timed to land on the first tick after that.
        key_speed_n = 1'b0;
        repeat (8) @(negedge clk);
        key_mode_n = 1'b0;
        wait_mode(2'd1, 20, n);
        check("col_latency", n, 32'd11);
        check("col_led", int'(led), 32'h01);
        check("col_speed", int'(speed), 32'd1);
        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
        wait_change(20, n);
        check("col_next_period", n, 32'd8);
        check("col_next_led", int'(led), 32'h02);
        check_run("col_bounce", col_exp, 8);

        // Now at pos 5 going down: pulse reset within one clock low phase.
        #1 rst_n = 1'b0;
        #1;
        check("arst_led", int'(led), 32'h01);
        check("arst_mode", int'(mode), 32'd0);
        check("arst_speed", int'(speed), 32'd0);
        #1 rst_n = 1'b1;
        wait_change(40, n);
        check("arst_first_step", n, 32'd16);
        check("arst_step_led", int'(led), 32'h02);
        check("arst_step_mode", int'(mode), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
